// File: rtl/mont_shift_ctrl_pkg.sv
// Shared types and sizing helpers for the radix-4 Montgomery shift sequencer.
// The STEPS/CNT_W helpers keep the interface and the controller sized identically.
package mont_shift_ctrl_pkg;

  localparam int RADIX_BITS = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DIGIT,
    ADD_WAIT,
    SHIFT,
    SWAIT,
    DONE
  } state_e;

  function automatic int steps_of(input int n_bits);
    return n_bits / RADIX_BITS;
  endfunction

  // A single-digit pass still needs a 1-bit counter.
  function automatic int cnt_w_of(input int n_bits);
    return (steps_of(n_bits) > 1) ? $clog2(steps_of(n_bits)) : 1;
  endfunction

endpackage

// File: rtl/mont_shift_ctrl_if.sv
// Control bundle between the multiplier FSM, the shift register / adder datapath
// and the shift sequencer; master is the sequencer side.
interface mont_shift_ctrl_if
  import mont_shift_ctrl_pkg::*;
#(
  parameter int N_BITS = 1024
) ();

  localparam int CNT_W = cnt_w_of(N_BITS);

  logic                  start;
  logic                  abort;
  logic                  sr_enable;
  logic                  sr_shift;
  logic                  sr_shift_done;
  logic [RADIX_BITS-1:0] sr_lsb;
  logic                  add_start;
  logic                  add_done;
  logic [RADIX_BITS-1:0] digit;
  logic [CNT_W-1:0]      iter_cnt;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, abort, sr_shift_done, sr_lsb, add_done,
    output sr_enable, sr_shift, add_start, digit, iter_cnt, busy, done
  );

  modport slave (
    output start, abort, sr_shift_done, sr_lsb, add_done,
    input  sr_enable, sr_shift, add_start, digit, iter_cnt, busy, done
  );

endinterface

// File: rtl/mont_shift_ctrl.sv
// Sequences one radix-4 Montgomery pass: load, then per digit launch the adder,
// wait for it, and shift the operand register right by two bits.
module mont_shift_ctrl
  import mont_shift_ctrl_pkg::*;
#(
  parameter int N_BITS = 1024
) (
  input  logic              clk,
  input  logic              restn,
  mont_shift_ctrl_if.master bus
);

  localparam int              STEPS = steps_of(N_BITS);
  localparam int              CNT_W = cnt_w_of(N_BITS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  state_e                r_state;
  state_e                w_next;
  logic                  r_sr_enable, r_sr_shift, r_add_start, r_busy, r_done;
  logic                  w_sr_enable, w_sr_shift, w_add_start, w_busy, w_done;
  logic [RADIX_BITS-1:0] r_digit;
  logic [CNT_W-1:0]      r_iter_cnt;
  logic                  w_last;

  assign w_last = (r_iter_cnt == LAST);

  // Strobes are registered from the next state so each one lines up with its state.
  always_ff @(posedge clk or negedge restn) begin
    if (!restn) begin
      r_state     <= IDLE;
      r_sr_enable <= 1'b0;
      r_sr_shift  <= 1'b0;
      r_add_start <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_sr_enable <= w_sr_enable;
      r_sr_shift  <= w_sr_shift;
      r_add_start <= w_add_start;
      r_busy      <= w_busy;
      r_done      <= w_done;
    end
  end

  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) begin
      if (bus.start && !bus.abort) w_next = LOAD;
    end else if (bus.abort) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        LOAD:     w_next = DIGIT;
        DIGIT:    w_next = ADD_WAIT;
        ADD_WAIT: if (bus.add_done) w_next = SHIFT;
        SHIFT:    w_next = SWAIT;
        SWAIT:    if (bus.sr_shift_done) w_next = w_last ? DONE : DIGIT;
        DONE:     w_next = IDLE;
        default:  w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    w_sr_enable = (w_next == LOAD);
    w_sr_shift  = (w_next == SHIFT);
    w_add_start = (w_next == DIGIT);
    w_done      = (w_next == DONE);
    w_busy      = (w_next != IDLE);
  end

  // The shift register only presents the loaded operand one cycle after LOAD,
  // so the digit is captured at the end of the DIGIT cycle; abort freezes both.
  always_ff @(posedge clk or negedge restn) begin
    if (!restn) begin
      r_digit    <= '0;
      r_iter_cnt <= '0;
    end else if (!bus.abort) begin
      if (r_state == DIGIT) r_digit <= bus.sr_lsb;
      if (r_state == LOAD) begin
        r_iter_cnt <= '0;
      end else if (r_state == SWAIT && bus.sr_shift_done && !w_last) begin
        r_iter_cnt <= r_iter_cnt + 1'b1;
      end
    end
  end

  assign bus.sr_enable = r_sr_enable;
  assign bus.sr_shift  = r_sr_shift;
  assign bus.add_start = r_add_start;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.digit     = r_digit;
  assign bus.iter_cnt  = r_iter_cnt;

endmodule

// File: tb/tb_mont_shift_ctrl.sv
// Bench for mont_shift_ctrl: shift register and variable-latency adder models,
// a timeline reference model of a pass, directed scenarios and random traffic.
module tb_mont_shift_ctrl;
  import mont_shift_ctrl_pkg::*;

  localparam int NB    = 8;
  localparam int STEPS = NB / 2;

  logic clk   = 1'b0;
  logic restn = 1'b0;
  always #5 clk = ~clk;

  mont_shift_ctrl_if #(.N_BITS(NB)) bus ();
  mont_shift_ctrl #(.N_BITS(NB)) dut (.clk(clk), .restn(restn), .bus(bus));

  int checks   = 0;
  int failures = 0;

  logic [NB-1:0] operand = '0;
  int            lat     = 1;
  logic          noise_ad = 1'b0;
  logic          noise_sd = 1'b0;

  // Datapath models: shift register acks one cycle after sr_shift,
  // adder raises add_done lat cycles after add_start.
  logic [NB-1:0] sr;
  logic          sd_r;
  int            ad_cnt;
  always @(posedge clk or negedge restn) begin
    if (!restn) begin
      sr <= '0; sd_r <= 1'b0; ad_cnt <= 0;
    end else begin
      if (bus.sr_enable) sr <= operand;
      else if (bus.sr_shift) sr <= sr >> 2;
      sd_r <= bus.sr_shift;
      if (bus.add_start) ad_cnt <= lat;
      else if (ad_cnt > 0) ad_cnt <= ad_cnt - 1;
    end
  end
  assign bus.sr_lsb        = sr[1:0];
  assign bus.sr_shift_done = sd_r | noise_sd;
  assign bus.add_done      = (ad_cnt == 1) | noise_ad;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a pass is a timeline of 1 load cycle, STEPS digit
  // periods of (3+lat) cycles each, and one done cycle.
  bit            m_act = 0;
  int            m_c = 0;
  int            m_lat = 1;
  logic [NB-1:0] m_op = '0;
  logic [1:0]    m_digit = '0;
  int            m_iter = 0;
  bit            m_addwait = 0;
  bit            m_swait = 0;
  int            done_seen = 0;
  logic          prev_as = 1'b0;
  logic [1:0]    dig_q[$];
  int            iter_q[$];

  always @(posedge clk) begin
    int P, k, i, p;
    bit e_en, e_sh, e_as, e_dn;
    if (!restn) begin
      m_act = 0; m_digit = '0; m_iter = 0;
    end else if (m_act) begin
      if (bus.abort) m_act = 0;
      else begin
        m_c++;
        if (m_c > 2 + STEPS * (3 + m_lat)) m_act = 0;
      end
    end else if (bus.start && !bus.abort) begin
      m_act = 1; m_c = 1; m_lat = lat; m_op = operand;
    end
    e_en = 0; e_sh = 0; e_as = 0; e_dn = 0;
    m_addwait = 0; m_swait = 0;
    if (m_act) begin
      P = 3 + m_lat;
      if (m_c == 1) e_en = 1;
      else if (m_c == 2 + STEPS * P) e_dn = 1;
      else begin
        k = m_c - 2; i = k / P; p = k % P;
        e_as = (p == 0);
        e_sh = (p == 1 + m_lat);
        m_addwait = (p >= 1 && p <= m_lat);
        m_swait = (p == 2 + m_lat);
        m_iter = i;
        if (p >= 1) m_digit = m_op[2*i +: 2];
      end
    end
    #1;
    check("sr_enable", bus.sr_enable, e_en);
    check("sr_shift", bus.sr_shift, e_sh);
    check("add_start", bus.add_start, e_as);
    check("done", bus.done, e_dn);
    check("busy", bus.busy, m_act);
    check("iter_cnt", bus.iter_cnt, m_iter);
    check("digit", bus.digit, m_digit);
    if (bus.done) done_seen++;
    if (prev_as) dig_q.push_back(bus.digit);
    if (bus.add_start) iter_q.push_back(int'(bus.iter_cnt));
    prev_as = bus.add_start;
  end

  task automatic kick(input logic [NB-1:0] op, input int a);
    @(negedge clk);
    operand = op; lat = a; bus.start = 1'b1;
    @(posedge clk);
    #2 bus.start = 1'b0;
  endtask

  task automatic run_pass(input logic [NB-1:0] op, input int a, input int exp_cyc,
                          input logic [1:0] ed [4]);
    int n;
    dig_q.delete(); done_seen = 0;
    kick(op, a);
    n = 1;
    while (!bus.done && n < 200) begin
      @(posedge clk); #2; n++;
    end
    check("done_latency", n, exp_cyc);
    check("iter_cnt_at_done", bus.iter_cnt, 3);
    check("busy_at_done", bus.busy, 1);
    @(posedge clk); #2;
    check("busy_after_done", bus.busy, 0);
    check("done_pulse_width", bus.done, 0);
    check("done_count", done_seen, 1);
    check("digit_count", dig_q.size(), 4);
    for (int j = 0; j < 4 && j < dig_q.size(); j++) check("digit_seq", dig_q[j], ed[j]);
  endtask

  logic [1:0] ed_a [4] = '{2'b00, 2'b11, 2'b01, 2'b10};
  logic [1:0] ed_b [4] = '{2'b01, 2'b10, 2'b11, 2'b00};

  initial begin
    int n;
    bus.start = 1'b0; bus.abort = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", bus.busy, 0);
    check("rst_iter_cnt", bus.iter_cnt, 0);
    check("rst_digit", bus.digit, 0);
    @(negedge clk); restn = 1'b1;

    run_pass(8'b10_01_11_00, 1, 18, ed_a);
    run_pass(8'b10_01_11_00, 5, 34, ed_a);

    // Second start in the middle of a pass
    iter_q.delete(); done_seen = 0;
    kick(8'b00_11_10_01, 2);
    n = 0;
    while (bus.iter_cnt != 2 && n < 200) begin @(posedge clk); #2; n++; end
    check("reached_iter2", (n < 200), 1);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    n = 0;
    while (bus.busy && n < 200) begin @(posedge clk); #2; n++; end
    repeat (10) @(posedge clk);
    #2;
    check("restart_done_count", done_seen, 1);
    check("restart_iter_len", iter_q.size(), 4);
    for (int j = 0; j < 4 && j < iter_q.size(); j++) check("restart_iter_seq", iter_q[j], j);

    // Abort in ADD_WAIT of iteration 1
    done_seen = 0;
    kick(8'b11_00_10_01, 3);
    n = 0;
    while (!(bus.add_start && bus.iter_cnt == 1) && n < 200) begin @(posedge clk); #2; n++; end
    check("reached_iter1", (n < 200), 1);
    @(posedge clk);
    @(negedge clk); bus.abort = 1'b1;
    @(posedge clk); #2;
    bus.abort = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_iter_hold", bus.iter_cnt, 1);
    check("abort_digit_hold", bus.digit, 2'b10);
    repeat (10) @(posedge clk);
    #2;
    check("abort_no_done", done_seen, 0);
    run_pass(8'b00_11_10_01, 2, 1 + 4 * 5 + 1, ed_b);

    // Asynchronous reset in SWAIT
    kick(8'b10_01_11_00, 1);
    n = 0;
    while (!(bus.sr_shift && bus.iter_cnt == 2) && n < 200) begin @(posedge clk); #2; n++; end
    check("reached_shift", (n < 200), 1);
    @(posedge clk); #2;
    restn = 1'b0;
    #1;
    check("arst_sr_enable", bus.sr_enable, 0);
    check("arst_sr_shift", bus.sr_shift, 0);
    check("arst_add_start", bus.add_start, 0);
    check("arst_digit", bus.digit, 0);
    check("arst_iter_cnt", bus.iter_cnt, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    @(posedge clk);
    @(negedge clk); restn = 1'b1;
    run_pass(8'b10_01_11_00, 1, 18, ed_a);

    // start and abort together while idle
    @(negedge clk); bus.start = 1'b1; bus.abort = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0; bus.abort = 1'b0;
    check("start_abort_sr_enable", bus.sr_enable, 0);
    check("start_abort_busy", bus.busy, 0);

    // Random traffic with glitches on the acknowledges outside their wait states
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (!m_act) begin
        operand = NB'($urandom);
        lat = $urandom_range(1, 6);
      end
      bus.start = ($urandom_range(0, 3) == 0);
      bus.abort = ($urandom_range(0, 59) == 0);
      noise_ad  = !m_addwait && ($urandom_range(0, 3) == 0);
      noise_sd  = !m_swait && ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0; noise_ad = 1'b0; noise_sd = 1'b0;
    n = 0;
    while (bus.busy && n < 200) begin @(posedge clk); #2; n++; end
    check("final_idle", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
